// File: rtl/lii_stream_downsizer.sv
// rtl/lii_stream_downsizer.sv - splits each PW-bit LII beat into RATIO OW-bit beats, with dst filtering
module lii_stream_downsizer #(
    parameter int         PW        = 128,
    parameter int         OW        = 64,
    parameter logic [7:0] MY_ID     = 8'h03,
    parameter logic [7:0] NEXT_ID   = 8'h04,
    parameter bit         FILTER_EN = 1'b1,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  logic [7:0]    lii_in_p0_src,
    input  logic [7:0]    lii_in_p0_dst,
    output logic [PW-1:0] lii_out_p0_tdata,
    output logic          lii_out_p0_tvalid,
    input  logic          lii_out_p0_tready,
    output logic [7:0]    lii_out_p0_src,
    output logic [7:0]    lii_out_p0_dst,
    output logic [15:0]   drop_cnt,
    output logic          busy
);
    localparam int RATIO = PW / OW;
    localparam int SW    = (RATIO > 2) ? 2 : 1;
    localparam logic [SW-1:0] LAST = SW'(RATIO - 1);

    logic [PW-1:0] buf_q, buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          out_fire, in_fire, dst_ok, accept, drop, last;
    logic [SW-1:0] idx;
    logic [OW-1:0] slice;
    logic          unused_src;

    // Source ID is carried on the bus but has no routing meaning at this hop.
    assign unused_src = ^lii_in_p0_src;

    always_comb begin
        out_fire         = buf_valid_q & lii_out_p0_tready;
        last             = (sel_q == LAST);
        lii_in_p0_tready = !buf_valid_q | (last & out_fire);
        in_fire          = lii_in_p0_tvalid & lii_in_p0_tready;
        dst_ok           = !FILTER_EN | (lii_in_p0_dst == MY_ID);
        accept           = in_fire & dst_ok;
        drop             = in_fire & !dst_ok;

        idx   = LSB_FIRST ? sel_q : (LAST - sel_q);
        slice = buf_q[idx*OW +: OW];

        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        sel_d       = sel_q;
        drop_cnt_d  = drop_cnt_q;

        if (out_fire) begin
            if (!last) begin
                sel_d = sel_q + 1'b1;
            end else begin
                sel_d       = '0;
                buf_valid_d = 1'b0;
            end
        end
        // A reload on the last slice overrides the clear above.
        if (accept) begin
            buf_d       = lii_in_p0_tdata;
            buf_valid_d = 1'b1;
            sel_d       = '0;
        end
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            sel_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            sel_q       <= sel_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign lii_out_p0_tvalid = buf_valid_q;
    assign lii_out_p0_tdata  = buf_valid_q ? {{(PW-OW){1'b0}}, slice} : '0;
    assign lii_out_p0_src    = MY_ID;
    assign lii_out_p0_dst    = NEXT_ID;
    assign drop_cnt          = drop_cnt_q;
    assign busy              = buf_valid_q;
endmodule

// File: tb/tb_lii_stream_downsizer.sv
// tb/tb_lii_stream_downsizer.sv - randomized bench with a slice-queue reference model
module tb_lii_stream_downsizer;
    localparam int         PW      = 128;
    localparam int         OW      = 64;
    localparam int         RATIO   = PW / OW;
    localparam logic [7:0] MY_ID   = 8'h03;
    localparam logic [7:0] NEXT_ID = 8'h04;

    logic          aclk = 1'b0;
    logic          arstn = 1'b0;
    logic [PW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [7:0]    in_src = 8'h02;
    logic [7:0]    in_dst = MY_ID;
    logic [PW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic [7:0]    out_src, out_dst;
    logic [15:0]   drop_cnt;
    logic          busy;

    lii_stream_downsizer dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_p0_tdata(in_tdata), .lii_in_p0_tvalid(in_tvalid), .lii_in_p0_tready(in_tready),
        .lii_in_p0_src(in_src), .lii_in_p0_dst(in_dst),
        .lii_out_p0_tdata(out_tdata), .lii_out_p0_tvalid(out_tvalid), .lii_out_p0_tready(out_tready),
        .lii_out_p0_src(out_src), .lii_out_p0_dst(out_dst),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted beat becomes RATIO expected output words, in emission order.
    logic [PW-1:0] exp_q[$];
    int            drop_m = 0;
    int            sz;
    logic          in_took = 1'b0;

    function automatic logic [PW-1:0] slice_of(input logic [PW-1:0] beat, input int i);
        int k;
        logic [PW-1:0] mask;
        k    = i;
        mask = (128'd1 << OW) - 128'd1;
        return (beat >> (k * OW)) & mask;
    endfunction

    always @(negedge aclk) begin
        if (!arstn) begin
            exp_q.delete();
            drop_m  = 0;
            in_took = 1'b0;
            chk("rst_tvalid", out_tvalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            chk("rst_tdata", out_tdata, 0);
        end else begin
            sz = exp_q.size();
            chk("tvalid", out_tvalid, sz > 0);
            chk("busy", busy, sz > 0);
            chk("drop_cnt", drop_cnt, drop_m);
            chk("in_tready", in_tready, (sz == 0) || (sz == 1 && out_tready));
            if (out_tvalid && sz > 0) begin
                chk("out_tdata", out_tdata, exp_q[0]);
                chk("out_dst", out_dst, NEXT_ID);
                chk("out_src", out_src, MY_ID);
                if (out_tready) void'(exp_q.pop_front());
            end else if (!out_tvalid) begin
                chk("idle_tdata", out_tdata, 0);
            end
            in_took = in_tvalid && in_tready;
            if (in_took) begin
                if (in_dst == MY_ID) begin
                    for (int i = 0; i < RATIO; i++) exp_q.push_back(slice_of(in_tdata, i));
                end else if (drop_m != 65535) begin
                    drop_m++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_one(input logic [PW-1:0] d, input logic [7:0] dst);
        in_tdata  = d;
        in_dst    = dst;
        in_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (in_took) break;
            if (i == 49) chk("send_timeout", 0, 1);
        end
        in_tvalid = 1'b0;
    endtask

    task automatic drive_random(input int n, input int ready_pct, input int drop_pct);
        for (int c = 0; c < n; c++) begin
            tick();
            if (!in_tvalid || in_took) begin
                in_tvalid = ($urandom % 100) < 70;
                in_tdata  = {$urandom, $urandom, $urandom, $urandom};
                in_dst    = (($urandom % 100) < drop_pct) ? 8'h07 : MY_ID;
                in_src    = 8'($urandom);
            end
            out_tready = ($urandom % 100) < ready_pct;
        end
        in_tvalid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        arstn = 1'b1;
        tick();
        chk("idle_in_tready", in_tready, 1);

        // Single beat, always-ready sink: two consecutive slices, low half first.
        out_tready = 1'b1;
        send_one(128'hAAAA_AAAA_AAAA_0000_1111_1111_1111_2222, MY_ID);
        repeat (4) tick();

        // Three back-to-back beats.
        in_tvalid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_tdata = {$urandom, $urandom, $urandom, $urandom};
            in_dst   = MY_ID;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (in_took) break;
            end
        end
        in_tvalid = 1'b0;
        repeat (8) tick();

        // Stall pattern 1,0,0,1 on the sink during a beat.
        out_tready = 1'b0;
        send_one(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, MY_ID);
        out_tready = 1'b1; tick();
        out_tready = 1'b0; tick();
        tick();
        out_tready = 1'b1;
        repeat (4) tick();

        // Filtered beat.
        send_one(128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, 8'h07);
        repeat (2) tick();
        chk("drop_one", drop_cnt, 1);

        drive_random(3000, 60, 20);
        drive_random(1000, 95, 5);
        out_tready = 1'b1;
        repeat (8) tick();

        // Reset after slice 0 of a beat has been consumed.
        out_tready = 1'b1;
        send_one(128'h5555_5555_5555_5555_6666_6666_6666_6666, MY_ID);
        tick();
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        tick();
        chk("post_rst_tvalid", out_tvalid, 0);
        send_one(128'h7777_7777_7777_7777_8888_8888_8888_8888, MY_ID);
        repeat (4) tick();

        // Saturation: keep dropping well past 65535.
        in_tvalid = 1'b1;
        in_dst    = 8'h07;
        repeat (65540) tick();
        in_tvalid = 1'b0;
        tick();
        chk("drop_sat", drop_cnt, 16'hFFFF);
        send_one(128'h9, MY_ID);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
